// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of every mem_arbiter signal except clk/rst.
//   Requester side : rdy, rollback, if_req/if_addr, ls_req/ls_we/ls_addr/
//                    ls_len/ls_wdata  ->  if_done/if_line, ls_done/ls_rdata
//   Memory side    : mem_din, io_buffer_full  ->  mem_a, mem_dout, mem_wr
// Modports:
//   slave  : the arbiter (serves requests, masters the byte-wide memory bus)
//   master : the environment (requesters plus memory)
// LINE_BYTES must match the arbiter's LINE_BYTES (sets the if_line width).
interface mem_arbiter_if #(
   parameter int unsigned LINE_BYTES = 16
);
   logic                    rdy;
   logic                    rollback;
   logic                    if_req;
   logic [31:0]             if_addr;
   logic                    if_done;
   logic [LINE_BYTES*8-1:0] if_line;
   logic                    ls_req;
   logic                    ls_we;
   logic [31:0]             ls_addr;
   logic [1:0]              ls_len;
   logic [31:0]             ls_wdata;
   logic                    ls_done;
   logic [31:0]             ls_rdata;
   logic [7:0]              mem_din;
   logic [7:0]              mem_dout;
   logic [31:0]             mem_a;
   logic                    mem_wr;
   logic                    io_buffer_full;

   modport slave (
      input  rdy, rollback,
      input  if_req, if_addr,
      input  ls_req, ls_we, ls_addr, ls_len, ls_wdata,
      input  mem_din, io_buffer_full,
      output if_done, if_line, ls_done, ls_rdata,
      output mem_dout, mem_a, mem_wr
   );

   modport master (
      output rdy, rollback,
      output if_req, if_addr,
      output ls_req, ls_we, ls_addr, ls_len, ls_wdata,
      output mem_din, io_buffer_full,
      input  if_done, if_line, ls_done, ls_rdata,
      input  mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one byte-wide memory port between an instruction-line
// refill port (if_*) and a load/store port (ls_*).
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : mem_arbiter_if.slave (requests, results and the memory bus)
// Reads present one address per cycle; memory returns each byte one cycle
// later, so a read spends one extra cycle collecting the final byte.
// Stores write one byte per cycle and stall while the I/O window
// (mem_a[17:16] == 2'b11) reports io_buffer_full.
// Build option: define MEM_ARBITER_RR_EN for round-robin arbitration between
// the two ports; otherwise ls_req always wins.
module mem_arbiter #(
   parameter int unsigned LINE_BYTES = 16
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   localparam int unsigned LINE_BITS = LINE_BYTES * 8;
   localparam int unsigned CW        = $clog2(LINE_BYTES) + 1;

   typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;

   state_t               state, state_nx;
   logic [CW-1:0]        cnt, cnt_nx, cnt_m1, nbytes;
   logic [31:0]          base, wdata, addr_cur;
   logic [7:0]           wr_byte;
   logic [LINE_BITS-1:0] line_buf, buf_nx, if_line_q;
   logic [31:0]          ls_rdata_q;
   logic                 sel_ls, pick_ls, grant, fin_rd, stall;

   assign cnt_m1   = cnt - CW'(1);
   assign addr_cur = base + 32'(cnt);
   assign wr_byte  = 8'(wdata >> {cnt[1:0], 3'b000});

`ifdef MEM_ARBITER_RR_EN
   // Set when the load/store port should win the next tie.
   logic rr_fav_ls;

   assign pick_ls = bus.ls_req && (!bus.if_req || rr_fav_ls);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_fav_ls <= 1'b0;
      else if (bus.rdy && grant)
         rr_fav_ls <= !pick_ls;
   end
`else
   assign pick_ls = bus.ls_req;
`endif

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      buf_nx       = line_buf;
      grant        = 1'b0;
      fin_rd       = 1'b0;
      stall        = 1'b0;
      bus.mem_a    = '0;
      bus.mem_dout = '0;
      bus.mem_wr   = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.rollback && (bus.if_req || bus.ls_req)) begin
               grant  = 1'b1;
               cnt_nx = '0;
               buf_nx = '0;
               if (!pick_ls)
                  state_nx = IF_RD;
               else if (bus.ls_we)
                  state_nx = LS_WR;
               else
                  state_nx = LS_RD;
            end
         end
         IF_RD, LS_RD: begin
            bus.mem_a = addr_cur;
            // Byte cnt-1 is on mem_din now; the buffer was cleared at grant,
            // so OR-ing it in leaves unread bytes zero.
            if (cnt != '0)
               buf_nx = line_buf | (LINE_BITS'(bus.mem_din) << {cnt_m1, 3'b000});
            if (bus.rollback) begin
               state_nx = IDLE;
            end else if (cnt == nbytes) begin
               state_nx = DONE;
               fin_rd   = 1'b1;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         LS_WR: begin
            bus.mem_a    = addr_cur;
            bus.mem_dout = wr_byte;
            stall        = (addr_cur[17:16] == 2'b11) && bus.io_buffer_full;
            bus.mem_wr   = bus.rdy && !stall;
            if (!stall) begin
               if (cnt == nbytes - CW'(1))
                  state_nx = DONE;
               else
                  cnt_nx = cnt + CW'(1);
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // All state advances only while rdy is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         nbytes     <= '0;
         base       <= '0;
         wdata      <= '0;
         sel_ls     <= 1'b0;
         line_buf   <= '0;
         if_line_q  <= '0;
         ls_rdata_q <= '0;
      end else if (bus.rdy) begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         line_buf <= buf_nx;
         if (grant) begin
            sel_ls <= pick_ls;
            wdata  <= bus.ls_wdata;
            if (pick_ls) begin
               base   <= bus.ls_addr;
               nbytes <= CW'(bus.ls_len) + CW'(1);
            end else begin
               base   <= bus.if_addr;
               nbytes <= CW'(LINE_BYTES);
            end
         end
         // Results are published only on completion so they stay stable
         // until the same port completes again.
         if (fin_rd) begin
            if (sel_ls)
               ls_rdata_q <= buf_nx[31:0];
            else
               if_line_q  <= buf_nx;
         end
      end
   end

   assign bus.if_done  = (state == DONE) && !sel_ls;
   assign bus.ls_done  = (state == DONE) &&  sel_ls;
   assign bus.if_line  = if_line_q;
   assign bus.ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed plus randomized self-checking bench for
// mem_arbiter. Expected behaviour comes from a transaction-level model:
// a progress count of effective (unpaused, unstalled) cycles, a memory
// content function and a log of observed writes.
module tb_mem_arbiter;
   localparam int unsigned LB    = 16;
   localparam int unsigned LBITS = LB * 8;
   localparam int K_IF = 0;
   localparam int K_LD = 1;
   localparam int K_ST = 2;

   logic clk = 1'b0;
   logic rst;

   mem_arbiter_if #(.LINE_BYTES(LB)) bus ();

   mem_arbiter #(.LINE_BYTES(LB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [39:0]      wr_q[$];
   bit               rr_fav_ls;
   logic [LBITS-1:0] prev_if;
   logic [31:0]      prev_ls;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      if (a >= 32'h100 && a <= 32'h103)
         return 8'(32'h11 * (a - 32'hFF));
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
   endfunction

   // Memory with one cycle of read latency; it pauses together with rdy.
   always @(posedge clk)
      if (bus.rdy === 1'b1)
         bus.mem_din <= mem_byte(bus.mem_a);

   always @(posedge clk)
      if (bus.mem_wr === 1'b1 && rst === 1'b0)
         wr_q.push_back({bus.mem_a, bus.mem_dout});

   task automatic check(input string tag, input logic [LBITS-1:0] obs,
                        input logic [LBITS-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input int kind, input logic [31:0] addr,
                        input logic [1:0] len, input logic [31:0] wdata);
      if (kind == K_IF) begin
         bus.if_req  = 1'b1;
         bus.if_addr = addr;
      end else begin
         bus.ls_req   = 1'b1;
         bus.ls_we    = (kind == K_ST);
         bus.ls_addr  = addr;
         bus.ls_len   = len;
         bus.ls_wdata = wdata;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_mem_a"},    bus.mem_a,    '0);
      check({tag, "_mem_wr"},   bus.mem_wr,   '0);
      check({tag, "_mem_dout"}, bus.mem_dout, '0);
      check({tag, "_if_done"},  bus.if_done,  '0);
      check({tag, "_ls_done"},  bus.ls_done,  '0);
   endtask

   // Called at a negedge in an IDLE cycle with the request already driven;
   // the next posedge is the grant. Returns at negedge+1 of an IDLE cycle.
   task automatic run_txn(input int kind, input logic [31:0] addr,
                          input logic [1:0] len, input logic [31:0] wdata,
                          input int pause_at, input int pause_len,
                          input int stall_len, input int rb_at);
      int n, p, done_p, pause_left, stall_left;
      bit fin, aborted, rb, iof, stall, rdy_v;
      logic [LBITS-1:0] exp_line;
      logic [31:0] a, w;
      n          = (kind == K_IF) ? int'(LB) : int'(len) + 1;
      done_p     = (kind == K_ST) ? n : n + 1;
      pause_left = pause_len;
      stall_left = stall_len;
      p          = 0;
      fin        = 1'b0;
      aborted    = 1'b0;
      exp_line   = '0;
      for (int i = 0; i < n; i++)
         exp_line[8*i +: 8] = mem_byte(addr + 32'(i));
      rr_fav_ls = (kind == K_IF);
      wr_q.delete();
      @(negedge clk);
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         rdy_v = !(p == pause_at && pause_left > 0);
         if (!rdy_v)
            pause_left--;
         rb  = rdy_v && (p == rb_at) && (kind != K_ST);
         iof = (stall_left > 0);
         if (stall_left > 0)
            stall_left--;
         bus.rdy            = rdy_v;
         // rollback is ignored while paused and never aborts a store
         bus.rollback       = (p == rb_at) || !rdy_v;
         bus.io_buffer_full = iof;
         #1;
         a     = addr + 32'(p);
         stall = (a[17:16] == 2'b11) && iof;
         if (p < n) begin
            check("mem_a", bus.mem_a, a);
            check("mem_wr", bus.mem_wr, (kind == K_ST) && rdy_v && !stall);
            if (kind == K_ST) begin
               w = wdata >> (8 * p);
               check("mem_dout", bus.mem_dout, w[7:0]);
            end
            check("if_done_early", bus.if_done, '0);
            check("ls_done_early", bus.ls_done, '0);
         end else if (p < done_p) begin
            check("tail_mem_wr", bus.mem_wr, '0);
            check("tail_if_done", bus.if_done, '0);
            check("tail_ls_done", bus.ls_done, '0);
         end else begin
            check("if_done", bus.if_done, kind == K_IF);
            check("ls_done", bus.ls_done, kind != K_IF);
            if (kind == K_IF) begin
               check("if_line", bus.if_line, exp_line);
               prev_if = exp_line;
            end else if (kind == K_LD) begin
               check("ls_rdata", bus.ls_rdata, exp_line[31:0]);
               prev_ls = exp_line[31:0];
            end
            fin = 1'b1;
         end
         if (rb) begin
            fin     = 1'b1;
            aborted = 1'b1;
         end else if (!fin && rdy_v && !(kind == K_ST && stall)) begin
            p++;
         end
         if (!fin)
            @(negedge clk);
      end
      check("completion", fin, 1'b1);
      if (kind == K_IF)
         bus.if_req = 1'b0;
      else
         bus.ls_req = 1'b0;
      @(negedge clk);
      bus.rollback       = 1'b0;
      bus.rdy            = 1'b1;
      bus.io_buffer_full = 1'b0;
      #1;
      check_idle(aborted ? "abort" : "after_done");
      check("if_line_hold", bus.if_line, prev_if);
      check("ls_rdata_hold", bus.ls_rdata, prev_ls);
      if (kind == K_ST) begin
         check("wr_count", wr_q.size(), n);
         for (int i = 0; i < n && i < wr_q.size(); i++) begin
            w = wdata >> (8 * i);
            check("wr_log", wr_q[i], {addr + 32'(i), w[7:0]});
         end
      end else begin
         check("no_writes", wr_q.size(), '0);
      end
      if (aborted) begin
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_idle("post_abort");
         end
      end
   endtask

   initial begin
      int kind, n, pause_at, pause_len, stall_len, rb_at;
      bit first_ls;
      logic [31:0] addr, wdata;
      logic [1:0] len;

      rst = 1'b1;
      bus.rdy = 1'b1;
      bus.rollback = 1'b0;
      bus.if_req = 1'b0;
      bus.if_addr = '0;
      bus.ls_req = 1'b0;
      bus.ls_we = 1'b0;
      bus.ls_addr = '0;
      bus.ls_len = '0;
      bus.ls_wdata = '0;
      bus.io_buffer_full = 1'b0;
      prev_if = '0;
      prev_ls = '0;
      rr_fav_ls = 1'b0;

      @(negedge clk);
      #1;
      check_idle("reset");
      check("reset_if_line", bus.if_line, '0);
      check("reset_ls_rdata", bus.ls_rdata, '0);
      @(negedge clk);
      rst = 1'b0;

      // Simultaneous fetch and load, both held until served.
      issue(K_IF, 32'h0000_2000, 2'd0, 32'h0);
      issue(K_LD, 32'h0000_0104, 2'd1, 32'h0);
`ifdef MEM_ARBITER_RR_EN
      first_ls = rr_fav_ls;
`else
      first_ls = 1'b1;
`endif
      if (first_ls) begin
         run_txn(K_LD, 32'h0000_0104, 2'd1, 32'h0, -1, 0, 0, -1);
         run_txn(K_IF, 32'h0000_2000, 2'd0, 32'h0, -1, 0, 0, -1);
      end else begin
         run_txn(K_IF, 32'h0000_2000, 2'd0, 32'h0, -1, 0, 0, -1);
         run_txn(K_LD, 32'h0000_0104, 2'd1, 32'h0, -1, 0, 0, -1);
      end

      // 4-byte load of 11 22 33 44.
      issue(K_LD, 32'h0000_0100, 2'd3, 32'h0);
      run_txn(K_LD, 32'h0000_0100, 2'd3, 32'h0, -1, 0, 0, -1);
      check("load_word", bus.ls_rdata, 32'h4433_2211);

      // Single-byte store into the I/O window with a 3-cycle full buffer.
      issue(K_ST, 32'h0003_0000, 2'd0, 32'h0000_0041);
      run_txn(K_ST, 32'h0003_0000, 2'd0, 32'h0000_0041, -1, 0, 3, -1);

      // Line fetch aborted by rollback in service cycle 7.
      issue(K_IF, 32'h0000_0000, 2'd0, 32'h0);
      run_txn(K_IF, 32'h0000_0000, 2'd0, 32'h0, -1, 0, 0, 7);

      // Two-byte load paused for 4 cycles after its first service cycle.
      issue(K_LD, 32'h0000_2345, 2'd1, 32'h0);
      run_txn(K_LD, 32'h0000_2345, 2'd1, 32'h0, 1, 4, 0, -1);

      // Reset pulsed during a 4-byte store, after its second byte.
      wr_q.delete();
      issue(K_ST, 32'h0000_0400, 2'd3, 32'hA1B2_C3D4);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("pre_rst_mem_a", bus.mem_a, 32'h0000_0401);
      check("pre_rst_mem_wr", bus.mem_wr, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      bus.ls_req = 1'b0;
      #1;
      check_idle("rst_mid");
      check("rst_mid_ls_rdata", bus.ls_rdata, '0);
      check("rst_mid_if_line", bus.if_line, '0);
      prev_if = '0;
      prev_ls = '0;
      rr_fav_ls = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_idle("after_rst");
      check("rst_wr_count", wr_q.size(), 2);
      if (wr_q.size() == 2) begin
         check("rst_wr0", wr_q[0], {32'h0000_0400, 8'hD4});
         check("rst_wr1", wr_q[1], {32'h0000_0401, 8'hC3});
      end
      issue(K_IF, 32'h0001_0040, 2'd0, 32'h0);
      run_txn(K_IF, 32'h0001_0040, 2'd0, 32'h0, -1, 0, 0, -1);

      // Randomized single-port traffic.
      for (int t = 0; t < 24; t++) begin
         kind = int'($urandom_range(2, 0));
         case ($urandom_range(2, 0))
            0:       len = 2'd0;
            1:       len = 2'd1;
            default: len = 2'd3;
         endcase
         addr  = $urandom();
         wdata = $urandom();
         if (kind == K_ST && $urandom_range(1, 0) == 1)
            addr[17:16] = 2'b11;
         n = (kind == K_IF) ? int'(LB) : int'(len) + 1;
         pause_len = int'($urandom_range(4, 1));
         if ($urandom_range(1, 0) == 1)
            pause_at = (kind == K_ST) ? int'($urandom_range(n - 1, 0))
                                      : int'($urandom_range(n, 0));
         else
            pause_at = -1;
         stall_len = (kind == K_ST) ? int'($urandom_range(3, 0)) : 0;
         rb_at = ($urandom_range(4, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
         issue(kind, addr, len, wdata);
         run_txn(kind, addr, len, wdata, pause_at, pause_len, stall_len, rb_at);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
